ndp_controller: RTL and testbench

// Command scheduler between the software register interface and up to 8 near-data-processing (NDP) units.
// - Queues software commands in a FIFO.
// - Dispatches commands in order when their target units are idle.
// - Tracks per-unit completion and exports pointer, occupancy and cycle-count telemetry for host reads.

---
 rtl/ndp_controller_if.sv | 29 ++
 rtl/ndp_controller.sv | 102 ++++++++++
 tb/tb_ndp_controller.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ndp_controller_if.sv
// rtl/ndp_controller_if.sv - Host register and NDP unit signal bundle for ndp_controller
`timescale 1ns/1ps
interface ndp_controller_if;
  logic [7:0]  ndp_status;
  logic [7:0]  ndp_done;
  logic [31:0] sw_cmd;
  logic [31:0] sw_reset;
  logic [31:0] ndp_complete;
  logic [7:0]  ndp_start;
  logic [63:0] time_cycles;
  logic [7:0]  read_ptr;
  logic [7:0]  write_ptr;
  logic        clobber_enable;
  logic [7:0]  max_write_read_diff;
  logic        offset_read_enable;
  logic [11:0] offset_read_addr;

  modport master (
    output ndp_status, ndp_done, sw_cmd, sw_reset,
    input  ndp_complete, ndp_start, time_cycles, read_ptr, write_ptr,
           clobber_enable, max_write_read_diff, offset_read_enable, offset_read_addr
  );

  modport slave (
    input  ndp_status, ndp_done, sw_cmd, sw_reset,
    output ndp_complete, ndp_start, time_cycles, read_ptr, write_ptr,
           clobber_enable, max_write_read_diff, offset_read_enable, offset_read_addr
  );
endinterface

// File: rtl/ndp_controller.sv
// rtl/ndp_controller.sv - In-order command FIFO and dispatcher for up to 8 NDP units
`timescale 1ns/1ps
module ndp_controller #(
  parameter int DEPTH = 16
) (
  input logic             clk,
  input logic             reset,
  ndp_controller_if.slave bus
);
  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_8 = 8'(DEPTH);

  // Entry layout: [20:9] offset address, [8] clobber, [7:0] unit mask.
  logic [20:0] mem_q [DEPTH];

  logic [7:0]  wp_q, wp_d, rp_q, rp_d, max_q, max_d;
  logic [7:0]  busy_q, busy_d, clob_q, clob_d, comp_q, comp_d, start_q, start_d;
  logic        ore_q, ore_d;
  logic [11:0] addr_q, addr_d;
  logic [63:0] time_q, time_d;

  logic [7:0]  occ, occ_d, head_mask;
  logic [20:0] head;
  logic        flush, push, launch;
  logic        unused_bits;

  assign flush     = bus.sw_reset[31];
  assign occ       = wp_q - rp_q;
  assign head      = mem_q[rp_q[AW-1:0]];
  assign head_mask = head[7:0];
  // Fullness is judged before any same-cycle pop, so a push into a full FIFO is lost.
  assign push      = (bus.sw_cmd[7:0] != 8'd0) && (occ != DEPTH_8) && !flush;
  assign launch    = (occ != 8'd0) && ((head_mask & (busy_q | bus.ndp_status)) == 8'd0) && !flush;

  assign unused_bits = ^{bus.sw_cmd[31:28], bus.sw_cmd[14:8], bus.sw_reset[30:8]};

  always_comb begin
    wp_d    = wp_q + {7'd0, push};
    rp_d    = rp_q + {7'd0, launch};
    occ_d   = wp_d - rp_d;
    max_d   = (occ_d > max_q) ? occ_d : max_q;
    busy_d  = (busy_q & ~bus.ndp_done) | (launch ? head_mask : 8'd0);
    clob_d  = (clob_q & ~bus.ndp_done) | ((launch && head[8]) ? head_mask : 8'd0);
    comp_d  = (comp_q & ~bus.sw_reset[7:0]) | bus.ndp_done;
    start_d = launch ? head_mask : 8'd0;
    ore_d   = launch;
    addr_d  = launch ? head[20:9] : addr_q;
    time_d  = (busy_q != 8'd0) ? time_q + 64'd1 : time_q;
    if (flush) begin
      wp_d    = 8'd0;
      rp_d    = 8'd0;
      max_d   = 8'd0;
      busy_d  = 8'd0;
      clob_d  = 8'd0;
      comp_d  = 8'd0;
      start_d = 8'd0;
      ore_d   = 1'b0;
      addr_d  = 12'd0;
      time_d  = 64'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[AW-1:0]] <= {bus.sw_cmd[27:16], bus.sw_cmd[15], bus.sw_cmd[7:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q    <= 8'd0;
      rp_q    <= 8'd0;
      max_q   <= 8'd0;
      busy_q  <= 8'd0;
      clob_q  <= 8'd0;
      comp_q  <= 8'd0;
      start_q <= 8'd0;
      ore_q   <= 1'b0;
      addr_q  <= 12'd0;
      time_q  <= 64'd0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      max_q   <= max_d;
      busy_q  <= busy_d;
      clob_q  <= clob_d;
      comp_q  <= comp_d;
      start_q <= start_d;
      ore_q   <= ore_d;
      addr_q  <= addr_d;
      time_q  <= time_d;
    end
  end

  assign bus.ndp_complete        = {24'd0, comp_q};
  assign bus.ndp_start           = start_q;
  assign bus.time_cycles         = time_q;
  assign bus.read_ptr            = rp_q;
  assign bus.write_ptr           = wp_q;
  assign bus.clobber_enable      = |clob_q;
  assign bus.max_write_read_diff = max_q;
  assign bus.offset_read_enable  = ore_q;
  assign bus.offset_read_addr    = addr_q;
endmodule

// File: tb/tb_ndp_controller.sv
// tb/tb_ndp_controller.sv - Randomized self-checking bench for ndp_controller
`timescale 1ns/1ps
module tb_ndp_controller;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  ndp_controller_if tif();
  ndp_controller #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(tif.slave));

  always #5 clk = ~clk;

  bit [31:0] mq[$];
  bit [7:0]  m_busy = 0, m_clob = 0, m_comp = 0, m_wp = 0, m_rp = 0, m_max = 0, m_start = 0;
  bit        m_ore = 0;
  bit [11:0] m_addr = 0;
  bit [63:0] m_time = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the FIFO is a queue of raw command words, occupancy is its size.
  always @(posedge clk or negedge reset) begin
    bit        launch, take;
    bit [31:0] head;
    if (!reset) begin
      mq.delete();
      m_busy = 0; m_clob = 0; m_comp = 0; m_wp = 0; m_rp = 0; m_max = 0;
      m_start = 0; m_ore = 0; m_addr = 0; m_time = 0;
    end else if (tif.sw_reset[31]) begin
      mq.delete();
      m_busy = 0; m_clob = 0; m_comp = 0; m_wp = 0; m_rp = 0; m_max = 0;
      m_start = 0; m_ore = 0; m_addr = 0; m_time = 0;
    end else begin
      take   = (tif.sw_cmd[7:0] != 0) && (mq.size() < DEPTH);
      launch = 0;
      head   = 0;
      if (mq.size() > 0) begin
        head   = mq[0];
        launch = (head[7:0] & (m_busy | tif.ndp_status)) == 0;
      end
      if (m_busy != 0) m_time++;
      m_busy  = m_busy & ~tif.ndp_done;
      m_clob  = m_clob & ~tif.ndp_done;
      m_comp  = (m_comp & ~tif.sw_reset[7:0]) | tif.ndp_done;
      m_start = 0;
      m_ore   = 0;
      if (launch) begin
        void'(mq.pop_front());
        m_busy  = m_busy | head[7:0];
        if (head[15]) m_clob = m_clob | head[7:0];
        m_start = head[7:0];
        m_ore   = 1;
        m_addr  = head[27:16];
        m_rp++;
      end
      if (take) begin
        mq.push_back(tif.sw_cmd);
        m_wp++;
      end
      if (mq.size() > m_max) m_max = 8'(mq.size());
    end
  end

  always @(negedge clk) begin
    logic [7:0] occ8;
    occ8 = tif.write_ptr - tif.read_ptr;
    check("ndp_start", tif.ndp_start, m_start);
    check("offset_read_enable", tif.offset_read_enable, m_ore);
    check("offset_read_addr", tif.offset_read_addr, m_addr);
    check("ndp_complete", tif.ndp_complete, {24'd0, m_comp});
    check("time_cycles", tif.time_cycles, m_time);
    check("write_ptr", tif.write_ptr, m_wp);
    check("read_ptr", tif.read_ptr, m_rp);
    check("occupancy", occ8, mq.size());
    check("max_write_read_diff", tif.max_write_read_diff, m_max);
    check("clobber_enable", tif.clobber_enable, m_clob != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] c;
    tif.sw_cmd = 0; tif.sw_reset = 0; tif.ndp_done = 0; tif.ndp_status = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("reset write_ptr", tif.write_ptr, 8'h00);
    check("reset ndp_start", tif.ndp_start, 8'h00);
    check("reset time_cycles", tif.time_cycles, 64'd0);

    tif.sw_cmd = 32'hdead0007; tick(); tif.sw_cmd = 0;
    check("first push write_ptr", tif.write_ptr, 8'd1);
    check("first push no start", tif.ndp_start, 8'h00);
    tick();
    check("first start", tif.ndp_start, 8'h07);
    check("first ore", tif.offset_read_enable, 1'b1);
    check("first addr", tif.offset_read_addr, 12'hEAD);
    check("first read_ptr", tif.read_ptr, 8'd1);
    tif.sw_cmd = 32'hcccc0008; tick(); tif.sw_cmd = 0; tick();
    check("second start", tif.ndp_start, 8'h08);
    check("second addr", tif.offset_read_addr, 12'hCCC);
    check("time after two", tif.time_cycles, 64'd2);
    tif.ndp_done = 8'h03; tick(); tif.ndp_done = 0;
    check("complete 0x3", tif.ndp_complete, 32'h3);
    tif.sw_reset = 32'h7; tick(); tif.sw_reset = 0;
    check("complete cleared", tif.ndp_complete, 32'h0);

    tif.sw_cmd = 32'hdeae0007; tick();
    tif.sw_cmd = 32'habcd0007; tick();
    tif.sw_cmd = 0; tick();
    check("blocked write_ptr", tif.write_ptr, 8'd4);
    check("blocked read_ptr", tif.read_ptr, 8'd2);
    tif.ndp_done = 8'h03; tick(); tif.ndp_done = 0; tick();
    check("still blocked", tif.ndp_start, 8'h00);
    tif.ndp_done = 8'h04; tick(); tif.ndp_done = 0; tick();
    check("released start", tif.ndp_start, 8'h07);
    check("released addr", tif.offset_read_addr, 12'hEAE);
    tif.ndp_done = 8'h07; tick(); tif.ndp_done = 0; tick();
    check("younger start", tif.ndp_start, 8'h07);
    check("younger addr", tif.offset_read_addr, 12'hBCD);
    tif.ndp_done = 8'h0f; tick(); tif.ndp_done = 0; tick();

    tif.sw_cmd = 32'h12348001; tick(); tif.sw_cmd = 0; tick();
    check("clobber set", tif.clobber_enable, 1'b1);
    tick(); tick();
    check("clobber held", tif.clobber_enable, 1'b1);
    tif.ndp_done = 8'h01; tick(); tif.ndp_done = 0;
    check("clobber cleared", tif.clobber_enable, 1'b0);

    tif.sw_cmd = 32'h00050003; tif.sw_reset = 32'h8000_0000; tick();
    tif.sw_cmd = 0; tif.sw_reset = 0;
    check("flush write_ptr", tif.write_ptr, 8'd0);
    check("flush read_ptr", tif.read_ptr, 8'd0);
    check("flush time", tif.time_cycles, 64'd0);
    check("flush max", tif.max_write_read_diff, 8'd0);

    tif.ndp_done = 8'h80; tick(); tif.ndp_done = 0;
    check("idle done complete", tif.ndp_complete, 32'h80);
    tif.ndp_done = 8'h80; tif.sw_reset = 32'h80; tick();
    check("set wins over clear", tif.ndp_complete, 32'h80);
    tif.ndp_done = 0; tick(); tif.sw_reset = 0;
    check("clear alone", tif.ndp_complete, 32'h0);

    tif.sw_cmd = 32'h00000001; tick(); tif.sw_cmd = 0; tick();
    tif.sw_cmd = 32'h00100001;
    repeat (DEPTH + 1) tick();
    tif.sw_cmd = 0;
    check("fill write_ptr", tif.write_ptr, 8'(DEPTH + 1));
    check("fill max", tif.max_write_read_diff, 8'(DEPTH));
    repeat (DEPTH) begin
      tif.ndp_done = 8'h01; tick(); tif.ndp_done = 0; tick();
    end
    check("drain read_ptr", tif.read_ptr, 8'(DEPTH + 1));

    for (int i = 0; i < 4000; i++) begin
      c = 0;
      if ($urandom_range(0, 1) == 0) begin
        c = $urandom();
        case ($urandom_range(0, 5))
          0:       c[7:0] = 8'h00;
          1:       c[7:0] = 8'($urandom());
          default: c[7:0] = 8'(1 << $urandom_range(0, 7));
        endcase
      end
      tif.sw_cmd     = c;
      tif.ndp_status = ($urandom_range(0, 9) == 0) ? 8'($urandom()) : 8'h00;
      tif.ndp_done   = ($urandom_range(0, 3) == 0) ? (m_busy & 8'($urandom())) : 8'h00;
      tif.sw_reset   = ($urandom_range(0, 19) == 0) ? {24'd0, 8'($urandom())} : 32'd0;
      if ($urandom_range(0, 599) == 0) tif.sw_reset[31] = 1'b1;
      tick();
    end
    tif.sw_cmd = 0; tif.ndp_status = 0; tif.ndp_done = 0;
    tif.sw_reset = 32'h8000_0000; tick(); tif.sw_reset = 0;

    tif.sw_cmd = 32'h0abc0002; tick(); tif.sw_cmd = 0; tick();
    check("pre-reset start", tif.ndp_start, 8'h02);
    #2 reset = 1'b0;
    #1;
    check("async reset start", tif.ndp_start, 8'h00);
    check("async reset ore", tif.offset_read_enable, 1'b0);
    check("async reset write_ptr", tif.write_ptr, 8'h00);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
